mem_stage_bus: RTL and testbench

- Parametrised successor of the single-cycle memory stage.
- Drives an external data memory over a req/gnt/rvalid bus with variable latency instead of an internal synchronous array.
- Stalls the pipeline while an access is outstanding, detects misaligned accesses, and supports XLEN=64 (LD/SD/LWU).
- Sits between the EX/MEM register and writeback and owns a registered MEM/WB output.

---
 rtl/mem_pkg.sv | 73 +++++++
 rtl/mem_stage_bus_loadext.sv | 39 +++
 rtl/mem_stage_bus.sv | 136 +++++++++++++
 tb/tb_mem_stage_bus.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the bus-based memory stage:
// funct3 codes, FSM states, access size decode and byte masks.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic {
    IDLE,
    WAIT_RSP
  } state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_D
  } size_t;

  // Anything not legal for the direction/XLEN falls back to a word.
  function automatic size_t access_size(
    input logic [2:0] f3,
    input logic       is_store,
    input logic       x64
  );
    size_t s;
    s = SZ_W;
    case (f3)
      F3_B:    s = SZ_B;
      F3_H:    s = SZ_H;
      F3_D:    s = x64 ? SZ_D : SZ_W;
      F3_BU:   s = is_store ? SZ_W : SZ_B;
      F3_HU:   s = is_store ? SZ_W : SZ_H;
      default: s = SZ_W;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] size_mask(input size_t s);
    logic [7:0] m;
    m = 8'h0F;
    case (s)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      SZ_D:    m = 8'hFF;
      default: m = 8'h0F;
    endcase
    return m;
  endfunction

  function automatic logic misaligned(
    input size_t      s,
    input logic [2:0] off
  );
    logic m;
    m = 1'b0;
    case (s)
      SZ_B:    m = 1'b0;
      SZ_H:    m = off[0];
      SZ_W:    m = |off[1:0];
      SZ_D:    m = |off;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_bus_loadext.sv
// Load data alignment: picks the addressed lane and
// sign- or zero-extends it according to funct3.
module loadext_gen
  import mem_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int OFFW = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [OFFW-1:0] i_off,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] w_sh;
  logic [7:0]      w_b;
  logic [15:0]     w_h;
  logic [31:0]     w_w;

  assign w_sh = i_rdata >> {i_off, 3'b000};
  assign w_b  = w_sh[7:0];
  assign w_h  = w_sh[15:0];
  assign w_w  = w_sh[31:0];

  // On XLEN=32 the full-width case degenerates to a plain word.
  always_comb begin
    o_data = XLEN'($signed(w_w));
    case (i_funct3)
      F3_B:    o_data = XLEN'($signed(w_b));
      F3_H:    o_data = XLEN'($signed(w_h));
      F3_BU:   o_data = XLEN'(w_b);
      F3_HU:   o_data = XLEN'(w_h);
      F3_WU:   o_data = XLEN'(w_w);
      F3_D:    o_data = w_sh;
      default: o_data = XLEN'($signed(w_w));
    endcase
  end

endmodule

// File: rtl/mem_stage_bus.sv
// Memory stage driving an external req/gnt/rvalid data bus,
// stalling while an access is outstanding; owns MEM/WB.
module mem_stage_bus
  import mem_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            funct3,
  input  logic [XLEN-1:0]       ALUResult,
  input  logic [XLEN-1:0]       WriteData,
  input  logic                  RegWrite,
  input  logic [1:0]            ResultSrc,
  input  logic [4:0]            Rd,
  input  logic [XLEN-1:0]       PCPlus4,
  input  logic [XLEN-1:0]       ImmExt,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN/8-1:0]     mem_be,
  output logic [XLEN-1:0]       mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic                  StallM,
  output logic [4:0]            RdM,
  output logic                  RegWriteM,
  output logic [XLEN-1:0]       ALUResultM,
  output logic                  wb_valid,
  output logic                  wb_RegWrite,
  output logic [1:0]            wb_ResultSrc,
  output logic [XLEN-1:0]       wb_ALUResult,
  output logic [4:0]            wb_Rd,
  output logic [XLEN-1:0]       wb_PCPlus4,
  output logic [XLEN-1:0]       wb_ImmExt,
  output logic [XLEN-1:0]       wb_load_data,
  output logic                  wb_misaligned
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  state_t          r_state;
  state_t          w_next;
  size_t           w_size;
  logic [OFFW-1:0] w_off;
  logic            w_memop;
  logic            w_mis;
  logic            w_done;
  logic            w_ld_done;
  logic [XLEN-1:0] w_ext;

  assign w_off   = ALUResult[OFFW-1:0];
  assign w_memop = in_valid & (MemRead | MemWrite);
  assign w_size  = access_size(funct3, MemWrite, XLEN == 64);
  assign w_mis   = w_memop & misaligned(w_size, 3'(w_off));

  assign mem_we    = MemWrite;
  assign mem_addr  = {ALUResult[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
  assign mem_be    = NB'(size_mask(w_size)) << w_off;
  assign mem_wdata = WriteData << {w_off, 3'b000};

  assign RdM        = Rd;
  assign RegWriteM  = RegWrite;
  assign ALUResultM = ALUResult;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Stores are posted on grant; loads wait for rvalid.
  always_comb begin
    w_next  = r_state;
    mem_req = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      IDLE: begin
        mem_req = w_memop & ~w_mis;
        if (mem_req && mem_gnt) begin
          if (MemWrite) w_done = 1'b1;
          else          w_next = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (mem_rvalid) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
    endcase
  end

  assign w_ld_done = w_done & (r_state == WAIT_RSP);
  assign StallM    = w_memop & ~w_mis & ~w_done;

  loadext_gen #(.XLEN(XLEN)) u_loadext (
    .i_rdata (mem_rdata),
    .i_off   (w_off),
    .i_funct3(funct3),
    .o_data  (w_ext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid      <= 1'b0;
      wb_RegWrite   <= 1'b0;
      wb_ResultSrc  <= '0;
      wb_ALUResult  <= '0;
      wb_Rd         <= '0;
      wb_PCPlus4    <= '0;
      wb_ImmExt     <= '0;
      wb_load_data  <= '0;
      wb_misaligned <= 1'b0;
    end else if (StallM) begin
      wb_valid    <= 1'b0;
      wb_RegWrite <= 1'b0;
    end else begin
      wb_valid      <= in_valid;
      wb_RegWrite   <= RegWrite & ~w_mis;
      wb_ResultSrc  <= ResultSrc;
      wb_ALUResult  <= ALUResult;
      wb_Rd         <= Rd;
      wb_PCPlus4    <= PCPlus4;
      wb_ImmExt     <= ImmExt;
      wb_misaligned <= w_mis;
      if (w_ld_done) wb_load_data <= w_ext;
    end
  end

endmodule

// File: tb/tb_mem_stage_bus.sv
// Scoreboard bench for mem_stage_bus: one XLEN=32 and one
// XLEN=64 instance sharing a clock and instruction fields.
module tb_mem_stage_bus;
  import mem_pkg::*;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
    logic [63:0] alu;
    logic [63:0] pc;
    logic        chk;
    logic [63:0] ld;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  exp_t e32, e64;
  int n_chk = 0;
  int n_fail = 0;

  logic clk = 0;
  logic reset = 1;
  logic v32 = 0, v64 = 0;
  logic MemRead = 0, MemWrite = 0, RegWrite = 0;
  logic [2:0] funct3 = 0;
  logic [1:0] rsrc = 2'b01;
  logic [4:0] rd = 0;
  logic [63:0] alu = 0, wd = 0, pc = 0, imm = 0;
  logic gnt32 = 0, rv32 = 0, gnt64 = 0, rv64 = 0;
  logic [31:0] rdata32 = 0;
  logic [63:0] rdata64 = 0;

  logic req32, we32, stall32, rwm32, wbv32, wbrw32, wbmis32;
  logic [15:0] addr32;
  logic [3:0] be32;
  logic [31:0] wdata32, alum32, wbalu32, wbpc32, wbimm32, wbld32;
  logic [4:0] rdm32, wbrd32;
  logic [1:0] wbrs32;

  logic req64, we64, stall64, rwm64, wbv64, wbrw64, wbmis64;
  logic [15:0] addr64;
  logic [7:0] be64;
  logic [63:0] wdata64, alum64, wbalu64, wbpc64, wbimm64, wbld64;
  logic [4:0] rdm64, wbrd64;
  logic [1:0] wbrs64;

  always #5 clk = ~clk;

  mem_stage_bus #(.XLEN(32), .ADDR_WIDTH(16)) d32 (
    .clk(clk), .reset(reset), .in_valid(v32),
    .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
    .ALUResult(alu[31:0]), .WriteData(wd[31:0]),
    .RegWrite(RegWrite), .ResultSrc(rsrc), .Rd(rd),
    .PCPlus4(pc[31:0]), .ImmExt(imm[31:0]),
    .mem_req(req32), .mem_we(we32), .mem_addr(addr32),
    .mem_be(be32), .mem_wdata(wdata32),
    .mem_gnt(gnt32), .mem_rvalid(rv32), .mem_rdata(rdata32),
    .StallM(stall32), .RdM(rdm32), .RegWriteM(rwm32),
    .ALUResultM(alum32), .wb_valid(wbv32),
    .wb_RegWrite(wbrw32), .wb_ResultSrc(wbrs32),
    .wb_ALUResult(wbalu32), .wb_Rd(wbrd32),
    .wb_PCPlus4(wbpc32), .wb_ImmExt(wbimm32),
    .wb_load_data(wbld32), .wb_misaligned(wbmis32)
  );

  mem_stage_bus #(.XLEN(64), .ADDR_WIDTH(16)) d64 (
    .clk(clk), .reset(reset), .in_valid(v64),
    .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
    .ALUResult(alu), .WriteData(wd),
    .RegWrite(RegWrite), .ResultSrc(rsrc), .Rd(rd),
    .PCPlus4(pc), .ImmExt(imm),
    .mem_req(req64), .mem_we(we64), .mem_addr(addr64),
    .mem_be(be64), .mem_wdata(wdata64),
    .mem_gnt(gnt64), .mem_rvalid(rv64), .mem_rdata(rdata64),
    .StallM(stall64), .RdM(rdm64), .RegWriteM(rwm64),
    .ALUResultM(alum64), .wb_valid(wbv64),
    .wb_RegWrite(wbrw64), .wb_ResultSrc(wbrs64),
    .wb_ALUResult(wbalu64), .wb_Rd(wbrd64),
    .wb_PCPlus4(wbpc64), .wb_ImmExt(wbimm64),
    .wb_load_data(wbld64), .wb_misaligned(wbmis64)
  );

  // Scoreboard: every valid writeback retires the oldest entry.
  always @(negedge clk) begin
    if (!reset && wbv32) begin
      n_chk++;
      if (q32.size() == 0) begin
        n_fail++;
        $display("FAIL wb32_unexpected rd=%0d alu=%h", wbrd32, wbalu32);
      end else begin
        e32 = q32.pop_front();
        if ({wbrd32, wbrw32, wbmis32} !== {e32.rd, e32.rw, e32.mis}) begin
          n_fail++;
          $display("FAIL wb32_ctrl got rd=%0d rw=%b mis=%b want rd=%0d rw=%b mis=%b",
                   wbrd32, wbrw32, wbmis32, e32.rd, e32.rw, e32.mis);
        end
        n_chk++;
        if (wbalu32 !== e32.alu[31:0] || wbpc32 !== e32.pc[31:0]) begin
          n_fail++;
          $display("FAIL wb32_data got alu=%h pc=%h want alu=%h pc=%h",
                   wbalu32, wbpc32, e32.alu[31:0], e32.pc[31:0]);
        end
        if (e32.chk) begin
          n_chk++;
          if (wbld32 !== e32.ld[31:0]) begin
            n_fail++;
            $display("FAIL wb32_load got %h want %h", wbld32, e32.ld[31:0]);
          end
        end
      end
    end
    if (!reset && wbv64) begin
      n_chk++;
      if (q64.size() == 0) begin
        n_fail++;
        $display("FAIL wb64_unexpected rd=%0d alu=%h", wbrd64, wbalu64);
      end else begin
        e64 = q64.pop_front();
        if ({wbrd64, wbrw64, wbmis64} !== {e64.rd, e64.rw, e64.mis}) begin
          n_fail++;
          $display("FAIL wb64_ctrl got rd=%0d rw=%b mis=%b want rd=%0d rw=%b mis=%b",
                   wbrd64, wbrw64, wbmis64, e64.rd, e64.rw, e64.mis);
        end
        n_chk++;
        if (wbalu64 !== e64.alu || wbpc64 !== e64.pc) begin
          n_fail++;
          $display("FAIL wb64_data got alu=%h pc=%h want alu=%h pc=%h",
                   wbalu64, wbpc64, e64.alu, e64.pc);
        end
        if (e64.chk) begin
          n_chk++;
          if (wbld64 !== e64.ld) begin
            n_fail++;
            $display("FAIL wb64_load got %h want %h", wbld64, e64.ld);
          end
        end
      end
    end
  end

  task automatic set_op(input logic r, input logic w,
                        input logic [2:0] f,
                        input logic [63:0] a, input logic [63:0] d,
                        input logic rw_i, input logic [4:0] rd_i,
                        input logic [63:0] pc_i);
    MemRead = r;
    MemWrite = w;
    funct3 = f;
    alu = a;
    wd = d;
    RegWrite = rw_i;
    rd = rd_i;
    pc = pc_i;
    imm = pc_i ^ 64'h5A5A;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1;
    @(negedge clk);
    n_chk++;
    if ({wbv32, wbrw32, wbmis32, stall32, req32} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset32_ctrl got %b want 00000",
               {wbv32, wbrw32, wbmis32, stall32, req32});
    end
    n_chk++;
    if (wbld32 !== 32'h0 || wbalu32 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset32_data got ld=%h alu=%h want 0", wbld32, wbalu32);
    end
    n_chk++;
    if ({wbv64, wbrw64, stall64, req64} !== 4'b0 || wbld64 !== 64'h0) begin
      n_fail++;
      $display("FAIL reset64 got v=%b ld=%h want 0", wbv64, wbld64);
    end
    next_cycle();
    reset = 0;
  endtask

  task automatic test_store_sw;
    set_op(0, 1, F3_W, 64'h104, 64'hDEADBEEF, 0, 5'd1, 64'h1000);
    v32 = 1;
    gnt32 = 1;
    q32.push_back('{rd: 5'd1, rw: 0, mis: 0, alu: 64'h104,
                    pc: 64'h1000, chk: 0, ld: 0});
    @(negedge clk);
    n_chk++;
    if ({req32, we32, be32} !== 6'b11_1111 || addr32 !== 16'h104) begin
      n_fail++;
      $display("FAIL sw_bus got req=%b we=%b be=%b addr=%h want 1 1 1111 0104",
               req32, we32, be32, addr32);
    end
    n_chk++;
    if (wdata32 !== 32'hDEADBEEF || stall32 !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_data got wdata=%h stall=%b want deadbeef 0",
               wdata32, stall32);
    end
    next_cycle();
    v32 = 0;
    gnt32 = 0;
  endtask

  task automatic test_load_lb;
    set_op(1, 0, F3_B, 64'h103, 64'h0, 1, 5'd2, 64'h1004);
    v32 = 1;
    rdata32 = 32'h80FFFFFF;
    q32.push_back('{rd: 5'd2, rw: 1, mis: 0, alu: 64'h103,
                    pc: 64'h1004, chk: 1, ld: 64'hFFFFFF80});
    for (int c = 0; c < 4; c++) begin
      gnt32 = (c == 0);
      rv32 = (c == 3);
      @(negedge clk);
      n_chk++;
      if (stall32 !== (c < 3) || req32 !== (c == 0)) begin
        n_fail++;
        $display("FAIL lb_cycle%0d got stall=%b req=%b want %b %b",
                 c, stall32, req32, (c < 3), (c == 0));
      end
      if (c == 0) begin
        n_chk++;
        if (be32 !== 4'b1000 || addr32 !== 16'h100) begin
          n_fail++;
          $display("FAIL lb_bus got be=%b addr=%h want 1000 0100", be32, addr32);
        end
      end
      next_cycle();
    end
    v32 = 0;
    gnt32 = 0;
    rv32 = 0;
  endtask

  task automatic test_store_sh;
    set_op(0, 1, F3_H, 64'h102, 64'h1234, 0, 5'd3, 64'h1008);
    v32 = 1;
    gnt32 = 1;
    q32.push_back('{rd: 5'd3, rw: 0, mis: 0, alu: 64'h102,
                    pc: 64'h1008, chk: 0, ld: 0});
    @(negedge clk);
    n_chk++;
    if (be32 !== 4'b1100 || wdata32 !== 32'h12340000 || stall32 !== 1'b0) begin
      n_fail++;
      $display("FAIL sh_bus got be=%b wdata=%h stall=%b want 1100 12340000 0",
               be32, wdata32, stall32);
    end
    next_cycle();
    v32 = 0;
    gnt32 = 0;
  endtask

  task automatic test_misaligned;
    set_op(1, 0, F3_W, 64'h106, 64'h0, 1, 5'd4, 64'h100C);
    v32 = 1;
    q32.push_back('{rd: 5'd4, rw: 0, mis: 1, alu: 64'h106,
                    pc: 64'h100C, chk: 0, ld: 0});
    @(negedge clk);
    n_chk++;
    if (req32 !== 1'b0 || stall32 !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_mis_bus got req=%b stall=%b want 0 0", req32, stall32);
    end
    next_cycle();
    v32 = 0;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) begin
      set_op(0, 0, F3_W, 64'h40 + 64'(i * 3), 64'h0, 1,
             5'(10 + i), 64'h2000 + 64'(i * 4));
      v32 = 1;
      q32.push_back('{rd: 5'(10 + i), rw: 1, mis: 0,
                      alu: 64'h40 + 64'(i * 3),
                      pc: 64'h2000 + 64'(i * 4), chk: 0, ld: 0});
      @(negedge clk);
      n_chk++;
      if (req32 !== 1'b0 || stall32 !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_%0d got req=%b stall=%b want 0 0", i, req32, stall32);
      end
      next_cycle();
    end
    v32 = 0;
  endtask

  task automatic test_lwu64;
    set_op(1, 0, F3_WU, 64'h204, 64'h0, 1, 5'd5, 64'h3000);
    v64 = 1;
    rdata64 = 64'h89ABCDEF_00000000;
    q64.push_back('{rd: 5'd5, rw: 1, mis: 0, alu: 64'h204,
                    pc: 64'h3000, chk: 1, ld: 64'h00000000_89ABCDEF});
    for (int c = 0; c < 2; c++) begin
      gnt64 = (c == 0);
      rv64 = (c == 1);
      @(negedge clk);
      n_chk++;
      if (stall64 !== (c == 0) || req64 !== (c == 0)) begin
        n_fail++;
        $display("FAIL lwu_cycle%0d got stall=%b req=%b want %b %b",
                 c, stall64, req64, (c == 0), (c == 0));
      end
      if (c == 0) begin
        n_chk++;
        if (be64 !== 8'hF0 || addr64 !== 16'h200) begin
          n_fail++;
          $display("FAIL lwu_bus got be=%h addr=%h want f0 0200", be64, addr64);
        end
      end
      next_cycle();
    end
    v64 = 0;
    gnt64 = 0;
    rv64 = 0;
  endtask

  task automatic test_sd64_delay;
    set_op(0, 1, F3_D, 64'h208, 64'h11223344_55667788, 0, 5'd6, 64'h3004);
    v64 = 1;
    q64.push_back('{rd: 5'd6, rw: 0, mis: 0, alu: 64'h208,
                    pc: 64'h3004, chk: 0, ld: 0});
    for (int c = 0; c < 3; c++) begin
      gnt64 = (c == 2);
      @(negedge clk);
      n_chk++;
      if (req64 !== 1'b1 || stall64 !== (c < 2)) begin
        n_fail++;
        $display("FAIL sd_cycle%0d got req=%b stall=%b want 1 %b",
                 c, req64, stall64, (c < 2));
      end
      if (c == 0) begin
        n_chk++;
        if (be64 !== 8'hFF || wdata64 !== 64'h11223344_55667788) begin
          n_fail++;
          $display("FAIL sd_bus got be=%h wdata=%h want ff 1122334455667788",
                   be64, wdata64);
        end
      end
      next_cycle();
    end
    v64 = 0;
    gnt64 = 0;
  endtask

  task automatic test_reset_midaccess;
    set_op(1, 0, F3_W, 64'h100, 64'h0, 1, 5'd7, 64'h4000);
    v32 = 1;
    gnt32 = 1;
    next_cycle();
    gnt32 = 0;
    @(negedge clk);
    n_chk++;
    if (stall32 !== 1'b1 || req32 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wait got stall=%b req=%b want 1 0", stall32, req32);
    end
    next_cycle();
    reset = 1;
    @(negedge clk);
    n_chk++;
    if (req32 !== 1'b1 || {wbv32, wbrw32} !== 2'b00 || wbld32 !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid got req=%b v=%b rw=%b ld=%h want 1 0 0 0",
               req32, wbv32, wbrw32, wbld32);
    end
    next_cycle();
    v32 = 0;
    reset = 0;
    rv32 = 1;
    rdata32 = 32'h12345678;
    @(negedge clk);
    n_chk++;
    if (stall32 !== 1'b0 || req32 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_stray got stall=%b req=%b want 0 0", stall32, req32);
    end
    next_cycle();
    rv32 = 0;
    @(negedge clk);
    n_chk++;
    if (wbld32 !== 32'h0 || wbv32 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ignore got ld=%h v=%b want 0 0", wbld32, wbv32);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_store_sw();
    test_load_lb();
    test_store_sh();
    test_misaligned();
    test_back_to_back();
    test_lwu64();
    test_sd64_delay();
    next_cycle();
    next_cycle();
    test_reset_midaccess();
    n_chk++;
    if (q32.size() != 0 || q64.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d/%0d pending want 0/0",
               q32.size(), q64.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
